vga_pixel_server: RTL
=====================

// Module: vga_pixel_server
// PURPOSE
//  Supplies pixel words to the VGA side in answer to the one-cycle request pulses that the VGA
//  request generator raises on every display-address change.
//  Buffers the captured CCD pixel stream in an internal FIFO and pops one word per request.
//  Primes the FIFO at each frame start, and flags underrun and overflow so that display tearing
//  can be diagnosed.
// PARAMETERS
//  DATA_W       30   pixel word width (10-bit R,G,B)
//  DEPTH_LOG2   9    FIFO depth = 2**DEPTH_LOG2 words
//  PRIME_LEVEL  256  FIFO fill level required before streaming starts (1..2**DEPTH_LOG2)
//  BLANK        0    word driven on oDATA for a request that cannot be served
// PORTS
//  iCLK          in   1             system clock; all logic on rising edge
//  iRST          in   1             synchronous, active-high reset
//  iDATA         in   DATA_W        captured pixel word
//  iDVAL         in   1             iDATA valid; push request
//  iFRAME_START  in   1             one-cycle pulse at frame start (vsync edge)
//  iREQ          in   1             one-cycle pixel request from the VGA request generator
//  oDATA         out  DATA_W        served pixel word
//  oDVAL         out  1             one-cycle strobe, oDATA valid
//  oLEVEL        out  DEPTH_LOG2+1  current FIFO occupancy, 0..2**DEPTH_LOG2
//  oSTREAMING    out  1             high in STREAM state
//  oUNDERRUN     out  1             sticky: request in STREAM with FIFO empty
//  oOVERFLOW     out  1             sticky: push dropped because FIFO full
// BEHAVIOUR
//  Reset (iRST=1 at an edge):
//  - Outputs: oDATA=BLANK, oDVAL=0, oLEVEL=0, oSTREAMING=0, oUNDERRUN=0, oOVERFLOW=0.
//  - FIFO pointers are cleared and the state is FILL. Reset overrides everything, mid-frame included.
//  State machine (FLUSH, FILL, STREAM):
//  - FLUSH: lasts one cycle. Clears the pointers, sets level to 0, clears both sticky flags, then goes to FILL.
//  - FILL:  goes to STREAM on the cycle after oLEVEL>=PRIME_LEVEL.
//  - STREAM: stays until a frame start or reset.
//  - iFRAME_START in any state goes to FLUSH and has priority over all other transitions.
//  - A push or pop in the same cycle as iFRAME_START is discarded.
//  - In FLUSH, iDVAL and iREQ are ignored except that iREQ still gets a BLANK answer with oDVAL.
//  Push:
//  - Accepted when iDVAL=1 and (level<DEPTH, or a pop occurs in the same cycle).
//  - When iDVAL=1, the FIFO is full and there is no same-cycle pop, the word is dropped and oOVERFLOW is set.
//  - Pushes are accepted in FILL and STREAM.
//  Request and serve:
//  - iREQ at edge N gives oDVAL=1 at edge N+1 (latency 1). oDVAL is high for exactly one cycle per iREQ.
//  - STREAM with level>0: pops the head word; oDATA = that word.
//  - STREAM with level=0: oDATA=BLANK, no pop, oUNDERRUN is set.
//  - There is no bypass. A push and a request in the same cycle on an empty FIFO count as an underrun,
//    and the pushed word stays in the FIFO.
//  - FILL or FLUSH: oDATA=BLANK, no pop, no underrun flag.
//  - oDATA holds its value between strobes.
//  Level:
//  - Simultaneous push and pop leaves the level unchanged.
//  - Pointers are DEPTH_LOG2 bits and wrap modulo 2**DEPTH_LOG2.
//  - oLEVEL is registered and is valid on the edge after the push or pop that changed it.
//  Storage:
//  - Single-clock dual-port RAM, registered read, sized so the 1-cycle latency holds.
//  - The read address is advanced combinationally from the pop decision.
// TESTING
//  1. Reset, push 256 words 1..256, then 4 iREQ pulses 2 cycles apart
//     -> oSTREAMING rises, oDATA 1,2,3,4, each one cycle after its iREQ, oLEVEL=252.
//  2. In FILL with level 10, iREQ -> oDATA=BLANK, oDVAL=1, oUNDERRUN=0, oLEVEL stays 10.
//  3. STREAM, drain to 0, then iREQ with iDVAL=1 in the same cycle
//     -> BLANK, oUNDERRUN=1, oLEVEL=1; the next iREQ returns the pushed word.
//  4. Fill to 512, push again with no pop -> word dropped, oOVERFLOW=1;
//     a push together with iREQ while full -> accepted, oLEVEL stays 512.
//  5. iFRAME_START mid-STREAM with level 100 and iREQ in the same cycle
//     -> BLANK served, next cycle oLEVEL=0, flags cleared, oSTREAMING=0.
//  6. iRST asserted mid-STREAM with flags set -> all outputs at reset values on the next edge,
//     priming restarts in FILL.

Source files
------------

// File: rtl/vga_pixel_server.sv
// vga_pixel_server
//   Buffers the captured CCD pixel stream in a FIFO and hands one word to the
//   VGA side for every one-cycle request pulse. The FIFO is primed at each
//   frame start, and streaming begins only once enough words are buffered.
//   Sticky underrun and overflow flags record any display tearing.
//
// Ports
//   iCLK          system clock, rising edge
//   iRST          synchronous active-high reset
//   iDATA         captured pixel word
//   iDVAL         iDATA valid (push request)
//   iFRAME_START  one-cycle frame-start pulse
//   iREQ          one-cycle pixel request
//   oDATA         served pixel word (holds between strobes)
//   oDVAL         one-cycle strobe, one cycle after each iREQ
//   oLEVEL        registered FIFO occupancy, 0..2**DEPTH_LOG2
//   oSTREAMING    high while streaming
//   oUNDERRUN     sticky: request while streaming with the FIFO empty
//   oOVERFLOW     sticky: push dropped because the FIFO was full
module vga_pixel_server #(
  parameter int                DATA_W      = 30,
  parameter int                DEPTH_LOG2  = 9,
  parameter int                PRIME_LEVEL = 256,
  parameter logic [DATA_W-1:0] BLANK       = '0
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [DATA_W-1:0]   iDATA,
  input  logic                iDVAL,
  input  logic                iFRAME_START,
  input  logic                iREQ,
  output logic [DATA_W-1:0]   oDATA,
  output logic                oDVAL,
  output logic [DEPTH_LOG2:0] oLEVEL,
  output logic                oSTREAMING,
  output logic                oUNDERRUN,
  output logic                oOVERFLOW
);

  localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PRIME_LVL  = (DEPTH_LOG2 + 1)'(PRIME_LEVEL);
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {FLUSH, FILL, STREAM} state_t;

  state_t                state;
  state_t                state_next;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]     ram_q;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_next;
  logic [DEPTH_LOG2:0]   level;
  logic                  show_word;
  logic                  dval;
  logic                  underrun;
  logic                  overflow;

  logic                  active;
  logic                  push;
  logic                  pop;
  logic                  underrun_hit;
  logic                  overflow_hit;

  always_ff @(posedge iCLK) begin
    if (iRST) state <= FILL;
    else      state <= state_next;
  end

  // A frame start always wins and forces a one-cycle flush.
  always_comb begin
    state_next = state;
    if (iFRAME_START) begin
      state_next = FLUSH;
    end else begin
      case (state)
        FLUSH:   state_next = FILL;
        FILL:    if (level >= PRIME_LVL) state_next = STREAM;
        STREAM:  state_next = STREAM;
        default: state_next = FILL;
      endcase
    end
  end

  // FIFO traffic is frozen during a flush and in the frame-start cycle.
  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  always_comb begin
    active       = !iFRAME_START && (state != FLUSH);
    pop          = active && iREQ && (state == STREAM) && (level != '0);
    underrun_hit = active && iREQ && (state == STREAM) && (level == '0);
    push         = active && iDVAL && ((level != FULL_LEVEL) || pop);
    overflow_hit = active && iDVAL && (level == FULL_LEVEL) && !pop;
    rd_ptr_next  = pop ? rd_ptr + PTR_ONE : rd_ptr;
  end

  // Dual-port storage with a registered read. The head word is captured
  // on the pop edge, so a word written one edge earlier is already visible.
  always_ff @(posedge iCLK) begin
    if (push) mem[wr_ptr] <= iDATA;
    if (pop)  ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge iCLK) begin
    if (iRST || (state == FLUSH)) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_ptr_next;
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST || (state == FLUSH)) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (underrun_hit) underrun <= 1'b1;
      if (overflow_hit) overflow <= 1'b1;
    end
  end

  // show_word selects between the popped word and BLANK. It only changes
  // on a request, so oDATA holds its value between strobes.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      dval      <= 1'b0;
      show_word <= 1'b0;
    end else begin
      dval <= iREQ;
      if (iREQ) show_word <= pop;
    end
  end

  assign oDATA      = show_word ? ram_q : BLANK;
  assign oDVAL      = dval;
  assign oLEVEL     = level;
  assign oSTREAMING = (state == STREAM);
  assign oUNDERRUN  = underrun;
  assign oOVERFLOW  = overflow;

endmodule
